// File: rtl/rv32_arb_pkg.sv
// Shared types for the two-port memory arbiter: owner IDs, arbiter states and the muxed request bundle.
package rv32_arb_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_arb_req_t;

endpackage

// File: rtl/rv32_arb_owner_fifo.sv
// Owner-ID FIFO recording which port each accepted request belongs to; head visible the same cycle.
// Latency: push visible at head one cycle later. Backpressure: full/empty flags; push when full and pop when empty are ignored.
module rv32_arb_owner_fifo
    import rv32_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  arb_owner_t push_owner,
    input  logic       pop,
    output arb_owner_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_owner_t     slots [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_owner;
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory port between fetch (m0) and data (m1): data-first priority, fetch starvation guard, in-order response routing.
// Combinational request/response paths; grant locks until accepted, requests block at MAX_OUTSTANDING. RV32_MEM_ARB_PERF_EN adds counters.
module rv32_mem_arbiter
    import rv32_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic        m0_req_we,
    input  logic [3:0]  m0_req_be,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_data,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic        m1_req_we,
    input  logic [3:0]  m1_req_be,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        err_spurious
`ifdef RV32_MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_m0_grants,
    output logic [31:0] perf_m1_grants,
    output logic [31:0] perf_full_stalls
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state, state_nxt;
    arb_owner_t    held, held_nxt;
    arb_owner_t    owner;
    arb_owner_t    head;
    logic [SW-1:0] starve_cnt;
    mem_arb_req_t  m0_req, m1_req, sel_req;
    logic          sel_valid;
    logic          xfer;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rsp_hit;

    assign m0_req = '{addr: m0_req_addr, we: m0_req_we, be: m0_req_be, wdata: m0_req_wdata};
    assign m1_req = '{addr: m1_req_addr, we: m1_req_we, be: m1_req_be, wdata: m1_req_wdata};

    always_comb begin
        owner     = held;
        state_nxt = state;
        held_nxt  = held;

        if (state == ARB_IDLE) begin
            if (starve_cnt == SW'(STARVE_LIMIT)) owner = ARB_M0;
            else if (m1_req_valid)               owner = ARB_M1;
            else                                 owner = ARB_M0;
        end

        sel_valid     = (owner == ARB_M1) ? m1_req_valid : m0_req_valid;
        sel_req       = (owner == ARB_M1) ? m1_req : m0_req;
        // A pop in the same cycle does not free a slot for this request.
        mem_req_valid = sel_valid && !fifo_full;
        xfer          = mem_req_valid && mem_req_ready;
        m0_req_ready  = xfer && (owner == ARB_M0);
        m1_req_ready  = xfer && (owner == ARB_M1);

        case (state)
            ARB_IDLE: begin
                if (mem_req_valid && !mem_req_ready) begin
                    state_nxt = ARB_HOLD;
                    held_nxt  = owner;
                end
            end
            ARB_HOLD: begin
                // Leaving on a dropped valid recovers from a requester that withdraws.
                if (xfer || !sel_valid) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign mem_req_addr  = sel_req.addr;
    assign mem_req_we    = sel_req.we;
    assign mem_req_be    = sel_req.be;
    assign mem_req_wdata = sel_req.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            held       <= ARB_M0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            held  <= held_nxt;
            if (m0_req_valid && !m0_req_ready) begin
                if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    rv32_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (xfer),
        .push_owner (owner),
        .pop        (mem_rsp_valid),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rsp_hit      = mem_rsp_valid && !fifo_empty;
    assign m0_rsp_valid = rsp_hit && (head == ARB_M0);
    assign m1_rsp_valid = rsp_hit && (head == ARB_M1);
    assign m0_rsp_data  = mem_rsp_data;
    assign m1_rsp_data  = mem_rsp_data;

    always_ff @(posedge clk) begin
        if (reset)                            err_spurious <= 1'b0;
        else if (mem_rsp_valid && fifo_empty) err_spurious <= 1'b1;
    end

`ifdef RV32_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_m0_grants   <= '0;
            perf_m1_grants   <= '0;
            perf_full_stalls <= '0;
        end else begin
            if (m0_req_ready) perf_m0_grants <= perf_m0_grants + 32'd1;
            if (m1_req_ready) perf_m1_grants <= perf_m1_grants + 32'd1;
            if ((m0_req_valid || m1_req_valid) && fifo_full)
                perf_full_stalls <= perf_full_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one physical memory port between the core's instruction-fetch requester (port 0) and data-access requester (port 1).
- Sits between the core's two memory ports and a single-ported memory/bus.
- Uses fixed priority (data first) with a starvation guard for fetch, locks the grant until the handshake completes, and routes in-order responses back through an outstanding-owner FIFO.

Parameters:
- MAX_OUTSTANDING, 4, depth of the owner FIFO; power of 2, >= 2.
- STARVE_LIMIT, 8, consecutive cycles port 0 may wait while port 1 wins before port 0 is forced; >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req_valid  in  1  port 0 (instruction) request valid.
- m0_req_ready  out  1  port 0 request accepted this cycle.
- m0_req_addr  in  32  port 0 byte address.
- m0_req_we  in  1  port 0 write enable.
- m0_req_be  in  4  port 0 byte enables.
- m0_req_wdata  in  32  port 0 write data.
- m0_rsp_valid  out  1  port 0 response pulse.
- m0_rsp_data  out  32  port 0 read data.
- m1_req_valid, m1_req_ready, m1_req_addr, m1_req_we, m1_req_be, m1_req_wdata, m1_rsp_valid, m1_rsp_data: same directions, widths and meanings as port 0, for port 1 (data).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr / mem_req_we / mem_req_be / mem_req_wdata  out  32/1/4/32  muxed request fields.
- mem_rsp_valid  in  1  one pulse per accepted request, in order.
- mem_rsp_data  in  32  response data.
- err_spurious  out  1  sticky: a response arrived while the FIFO was empty.

Behaviour:
- Transfers:
  - A request transfers when mem_req_valid && mem_req_ready.
  - Every transferred request, read or write, receives exactly one mem_rsp_valid in order, after at least 1 cycle.
- States:
  - ARB_IDLE: pick an owner each cycle.
  - ARB_HOLD: owner locked.
- Owner selection in ARB_IDLE:
  - Port 0 wins if starve_cnt == STARVE_LIMIT.
  - Otherwise port 1 wins if m1_req_valid.
  - Otherwise port 0 wins if m0_req_valid.
- Request outputs:
  - mem_req_valid = selected valid && !fifo_full.
  - Request fields are driven from the owner.
  - mX_req_ready = (owner == X) && mem_req_valid && mem_req_ready. These are combinational.
- State transitions:
  - IDLE->HOLD when mem_req_valid && !mem_req_ready.
  - HOLD keeps the same owner until transfer, then returns to IDLE.
  - HOLD is also exited if the owner drops its valid (protocol violation; no transfer occurs).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle m0_req_valid is high and port 0 does not transfer.
  - Clears on a port 0 transfer or when m0_req_valid is low.
- FIFO:
  - Pushes the owner ID on each transfer.
  - Pops on mem_rsp_valid.
  - Response is routed combinationally: mX_rsp_valid = mem_rsp_valid && head == X; mX_rsp_data = mem_rsp_data (both ports are driven with data; the valid signals select).
- Full/empty:
  - Full means occupancy == MAX_OUTSTANDING, which blocks mem_req_valid. A pop in the same cycle does not unblock it (no bypass).
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - mem_rsp_valid with an empty FIFO is dropped: no rsp_valid on either port, and err_spurious sets.
- Reset values: state=ARB_IDLE, starve_cnt=0, FIFO empty, err_spurious=0, all valid/ready outputs 0.
- Reset mid-operation: outstanding owners are discarded. The memory is reset in the same cycle.

Optional Feature:
- RV32_MEM_ARB_PERF_EN defined:
  - Adds three 32-bit outputs, perf_m0_grants, perf_m1_grants and perf_full_stalls.
  - perf_full_stalls counts cycles with any valid while fifo_full.
  - All three wrap, reset to 0, and increment on the respective events.
- Undefined: the ports and counters are absent, and there is no other behavioural change.

Decomposition:
- Package rv32_arb_pkg:
  - arb_owner_t enum (ARB_M0, ARB_M1).
  - arb_state_t enum (ARB_IDLE, ARB_HOLD).
  - mem_arb_req_t struct {addr, we, be, wdata}.
- Sub-module rv32_arb_owner_fifo:
  - Parameterised synchronous FIFO of arb_owner_t.
  - Ports: push/pop/head/full/empty.

Test Plan:
- Only m0 valid, addr 0x100, mem_req_ready=1, mem_rsp_data=0xDEADBEEF one cycle later -> m0_req_ready same cycle; m0_rsp_valid=1, m0_rsp_data=0xDEADBEEF; m1_rsp_valid=0.
- Both valid continuously, ready=1, STARVE_LIMIT=8 -> port 1 wins 8 cycles, then port 0 gets 1 grant, pattern repeats; responses are routed to the matching port in order.
- m0 selected with mem_req_ready=0 for 3 cycles, m1 asserts in cycle 1 -> owner stays port 0 (HOLD), address stable; port 0 transfers in cycle 4, then port 1 is granted.
- MAX_OUTSTANDING=4, 4 transfers with no responses -> mem_req_valid=0 on the 5th; a response in the cycle the 5th is pending -> blocked that cycle, accepted the next.
- mem_rsp_valid pulse with FIFO empty -> no port rsp_valid; err_spurious=1 until reset; reset high 1 cycle -> err_spurious=0, state IDLE.
- With RV32_MEM_ARB_PERF_EN, 5 m1 and 2 m0 transfers -> perf_m1_grants=5, perf_m0_grants=2.
